seq_add_nibble: RTL and testbench
=================================

Name: seq_add_nibble

Overview:
Multi-cycle N-bit adder that is the direct upstream driver of the team's 4-bit CLA slice. It latches two operands, then feeds one nibble per cycle to a single 4-bit CLA instance, registering the nibble carry between cycles. It assembles the sum and reports carry-out and signed overflow with a start/done handshake. It is used where area matters more than latency, for example in the multi-cycle ALU path.

Parameters:
N, 16, operand/result width; legal values 8, 16, 32 (multiple of 4); nibble count NIB = N/4.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only when busy=0.
a  input  N  operand A; captured on the accepting edge.
b  input  N  operand B; captured on the accepting edge.
c_in  input  1  carry into nibble 0; captured on the accepting edge.
busy  output  1  high while nibbles are being processed.
done  output  1  one-cycle pulse when sum/c_out/ofl are updated.
sum  output  N  registered result; holds its value until the next completion.
c_out  output  1  carry out of bit N-1.
ofl  output  1  signed two's-complement overflow.

Behaviour:
- Reset is synchronous and active-high, on one clock (clk).
- On rst: state=IDLE; nibble counter=0; carry reg=0; operand regs=0; sum=0; c_out=0; ofl=0; busy=0; done=0.
- States are IDLE, RUN, DONE.
- IDLE: if start=1, capture a, b, c_in and load carry reg with c_in. Set cnt=0 and go to RUN.
- RUN: each cycle, apply nibble cnt of A and B plus the carry reg to the CLA.
  - Write the CLA sum into nibble cnt of an internal accumulator.
  - Load the carry reg with the CLA c_out.
  - Increment cnt.
  - When cnt=NIB-1, instead go to DONE and load sum/c_out/ofl from the final accumulator and carry.
- DONE: lasts one cycle. done=1 and busy=0 in that cycle. If start=1 in this cycle, the request is accepted exactly as in IDLE (back-to-back operation). Otherwise go to IDLE.
- Latency: start high in cycle k, then busy=1 in cycles k+1..k+NIB and done=1 in cycle k+NIB+1. For N=16, done lands at k+5.
- Throughput: one result every NIB+1 cycles.
- busy is 1 exactly in RUN.
- sum/c_out/ofl change only on the completion edge. They never show partial results.
- ofl = (A[N-1]==B[N-1]) & (result[N-1]!=A[N-1]), using the captured operands.
- start while busy=1: ignored; it is not queued and the operands are not re-captured.
- a/b/c_in changing after acceptance: no effect on the operation in flight.
- rst during RUN: the operation is aborted and outputs are cleared; done is never pulsed for the aborted operation.
- rst and start in the same cycle: rst wins and the request is dropped.
- Arithmetic is modulo 2^N. The nibble carry chain is exact, so the result equals a+b+c_in.
- Counter is log2(NIB) bits wide; it never wraps past NIB-1 inside RUN.

Optional Feature:
SEQ_ADD_SUB_EN
- Defined: adds input port sub (1 bit), captured with the operands. When sub=1, the block stores ~b as operand B and forces the initial carry to 1, giving result = a-b. In that case c_out=1 means "no borrow", and ofl uses the inverted B sign bit. c_in is ignored when sub=1.
- Undefined: the sub port does not exist and the block is add-only. Behaviour is identical to the defined build with sub=0.

Test Plan:
- Reset then start with a=0x1234, b=0x4321, c_in=0 at cycle k → busy=1 in cycles k+1..k+4; done=1 in cycle k+5 only; sum=0x5555, c_out=0, ofl=0.
- a=0xFFFF, b=0x0001, c_in=0 → sum=0x0000, c_out=1, ofl=0. Then a=0x7FFF, b=0x0001 → sum=0x8000, c_out=0, ofl=1. Then a=0x000F, b=0x0000, c_in=1 → sum=0x0010 (carry crosses the nibble boundary).
- Start 0x0100+0x0200; pulse start with 0xAAAA+0x5555 in cycle k+2 → the second request is ignored; result is 0x0300 at k+5 and busy drops afterwards.
- Start 0x1111+0x2222, then hold start high in the done cycle with new operands 0x8000+0x8000 → the second operation is accepted back-to-back; its result is 0x0000, c_out=1, ofl=1, with done 5 cycles after the first done.
- Start 0x1234+0x1111 and assert rst in cycle k+2 → outputs are 0 from the next cycle and no done pulse ever appears; a fresh start afterwards completes normally.
- With SEQ_ADD_SUB_EN defined: a=0x0005, b=0x0007, sub=1 → sum=0xFFFE, c_out=0. a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, ofl=1.

Source files
------------

// File: rtl/seq_add_nibble_if.sv
// seq_add_nibble_if: request/result bundle for the nibble-serial adder.
// Optional macro: SEQ_ADD_SUB_EN adds the 'sub' request bit.
// Signals:
//   start      request, honoured only while the adder is not busy
//   a, b       N-bit operands, captured on the accepting edge
//   c_in       carry into nibble 0, captured on the accepting edge
//   sub        (SEQ_ADD_SUB_EN only) subtract request, captured with operands
//   busy       high while nibbles are being processed
//   done       one-cycle pulse when sum/c_out/ofl update
//   sum        registered result, held until the next completion
//   c_out      carry out of bit N-1
//   ofl        signed two's-complement overflow
// Modports: master drives the request, slave is the adder.
interface seq_add_nibble_if #(
  parameter int unsigned N = 16
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         c_in;
`ifdef SEQ_ADD_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         c_out;
  logic         ofl;

  modport master (
    output start, a, b, c_in,
`ifdef SEQ_ADD_SUB_EN
    output sub,
`endif
    input  busy, done, sum, c_out, ofl
  );

  modport slave (
    input  start, a, b, c_in,
`ifdef SEQ_ADD_SUB_EN
    input  sub,
`endif
    output busy, done, sum, c_out, ofl
  );
endinterface

// File: rtl/seq_add_nibble.sv
// seq_add_nibble: multi-cycle N-bit adder built around one 4-bit CLA slice.
// Operands are latched on start; one nibble is added per cycle with the
// nibble carry held in a register; the finished result is published with a
// one-cycle done pulse. Result equals a + b + c_in modulo 2^N.
// Optional macro: SEQ_ADD_SUB_EN enables subtraction (a - b) via bus.sub.
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous, active-high reset
//   bus   seq_add_nibble_if.slave (start/a/b/c_in[/sub] in,
//         busy/done/sum/c_out/ofl out)
module seq_add_nibble #(
  parameter int unsigned N = 16
) (
  input  logic            clk,
  input  logic            rst,
  seq_add_nibble_if.slave bus
);
  localparam int unsigned NIB = N / 4;
  localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [CW-1:0]  cnt;
  logic           carry;
  logic [N-1:0]   opa;
  logic [N-1:0]   opb;
  logic [N-1:0]   acc;
  logic [N-1:0]   acc_nx;
  logic [N-1:0]   b_in;
  logic           c_sel;
  logic [3:0]     nib_a;
  logic [3:0]     nib_b;
  logic [3:0]     nib_s;
  logic [3:0]     g;
  logic [3:0]     p;
  logic [3:0]     c;
  logic           nib_co;
  logic           last;
  logic           accept;
  logic           run;
  logic           busy_nx;
  logic           done_nx;
  logic           busy_q;
  logic           done_q;
  logic [N-1:0]   sum_q;
  logic           c_out_q;
  logic           ofl_q;

  assign last = (cnt == CW'(NIB - 1));

  // Subtraction stores ~b and forces the initial carry, so a + ~b + 1 = a - b.
`ifdef SEQ_ADD_SUB_EN
  assign b_in  = bus.sub ? ~bus.b : bus.b;
  assign c_sel = bus.sub | bus.c_in;
`else
  assign b_in  = bus.b;
  assign c_sel = bus.c_in;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = bus.start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output/control decode; DONE accepts a new request like IDLE does
  always_comb begin
    accept  = 1'b0;
    run     = 1'b0;
    busy_nx = (state_nx == RUN);
    done_nx = (state_nx == DONE);
    case (state)
      IDLE, DONE: accept = bus.start;
      RUN:        run    = 1'b1;
      default:    ;
    endcase
  end

  // Select the current nibble of each operand
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int unsigned i = 0; i < NIB; i++) begin
      if (cnt == CW'(i)) begin
        nib_a = opa[4*i +: 4];
        nib_b = opb[4*i +: 4];
      end
    end
  end

  // 4-bit carry-lookahead slice
  assign g    = nib_a & nib_b;
  assign p    = nib_a ^ nib_b;
  assign c[0] = carry;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign nib_co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);
  assign nib_s = p ^ c;

  // Accumulator with the current nibble merged in, so the last nibble can
  // be published on the same edge it is computed
  always_comb begin
    acc_nx = acc;
    for (int unsigned i = 0; i < NIB; i++) begin
      if (cnt == CW'(i)) acc_nx[4*i +: 4] = nib_s;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      carry   <= 1'b0;
      opa     <= '0;
      opb     <= '0;
      acc     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ofl_q   <= 1'b0;
    end else begin
      busy_q <= busy_nx;
      done_q <= done_nx;
      if (accept) begin
        opa   <= bus.a;
        opb   <= b_in;
        carry <= c_sel;
        cnt   <= '0;
      end else if (run) begin
        acc   <= acc_nx;
        carry <= nib_co;
        if (last) begin
          sum_q   <= acc_nx;
          c_out_q <= nib_co;
          ofl_q   <= (opa[N-1] == opb[N-1]) & (acc_nx[N-1] != opa[N-1]);
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;
  assign bus.ofl   = ofl_q;
endmodule

// File: tb/tb_seq_add_nibble.sv
// tb_seq_add_nibble: directed bench for seq_add_nibble with a cycle-level
// reference model compared every cycle, plus literal expectations.
// Optional macro: SEQ_ADD_SUB_EN enables the subtract vectors.
module tb_seq_add_nibble;
  localparam int unsigned N   = 16;
  localparam int unsigned NIB = N / 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_add_nibble_if #(.N(N)) bus ();
  seq_add_nibble #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a request accepted while idle produces a+b+c_in after
  // NIB busy cycles, then a one-cycle done.
  logic         m_busy, m_done, m_cout, m_ofl, p_ofl;
  logic [N-1:0] m_sum;
  logic [N:0]   p_res;
  int           m_left;

  always @(posedge clk) begin
    logic [N-1:0] bb;
    logic         cc;
    logic [N:0]   r;
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_sum  <= '0;
      m_cout <= 1'b0;
      m_ofl  <= 1'b0;
      m_left <= 0;
    end else if (m_busy) begin
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_sum  <= p_res[N-1:0];
        m_cout <= p_res[N];
        m_ofl  <= p_ofl;
      end else begin
        m_left <= m_left - 1;
      end
    end else begin
      m_done <= 1'b0;
      if (bus.start) begin
        bb = bus.b;
        cc = bus.c_in;
`ifdef SEQ_ADD_SUB_EN
        if (bus.sub) begin
          bb = ~bus.b;
          cc = 1'b1;
        end
`endif
        r      = {1'b0, bus.a} + {1'b0, bb} + (N+1)'(cc);
        p_res  <= r;
        p_ofl  <= (bus.a[N-1] == bb[N-1]) && (r[N-1] != bus.a[N-1]);
        m_busy <= 1'b1;
        m_left <= NIB;
      end
    end
  end

  // Compare DUT against the model every cycle
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("mdl_busy",  bus.busy,  m_busy);
      chk("mdl_done",  bus.done,  m_done);
      chk("mdl_sum",   bus.sum,   m_sum);
      chk("mdl_c_out", bus.c_out, m_cout);
      chk("mdl_ofl",   bus.ofl,   m_ofl);
    end
  end

  task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic ci, input logic sb);
    bus.a    = a;
    bus.b    = b;
    bus.c_in = ci;
`ifdef SEQ_ADD_SUB_EN
    bus.sub  = sb;
`else
    if (sb) $display("note: sub ignored in add-only build");
`endif
    bus.start = 1'b1;
  endtask

  // Wait for done, scrambling inputs after acceptance; optionally inject a
  // start pulse in cycle inj_at after acceptance.
  task automatic wait_done(input int inj_at, input logic [N-1:0] ia,
                           input logic [N-1:0] ib, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (n < 20 && !seen) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        bus.start = 1'b0;
        bus.a     = N'($urandom);
        bus.b     = N'($urandom);
        bus.c_in  = 1'($urandom);
      end
      if (inj_at != 0 && n == inj_at) begin
        bus.a     = ia;
        bus.b     = ib;
        bus.start = 1'b1;
      end
      if (inj_at != 0 && n == inj_at + 1) bus.start = 1'b0;
      if (n <= NIB) chk("lat_busy", bus.busy, 1);
      seen = bus.done;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=no_done required=done within 20 cycles");
    end
  endtask

  task automatic op(input string nm, input logic [N-1:0] a, input logic [N-1:0] b,
                    input logic ci, input logic sb, input logic [N-1:0] es,
                    input logic eco, input logic eo);
    int n;
    drive(a, b, ci, sb);
    wait_done(0, '0, '0, n);
    chk({nm, "_lat"},   n, NIB + 1);
    chk({nm, "_sum"},   bus.sum, es);
    chk({nm, "_c_out"}, bus.c_out, eco);
    chk({nm, "_ofl"},   bus.ofl, eo);
    chk({nm, "_busy"},  bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n2;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.c_in  = 1'b0;
`ifdef SEQ_ADD_SUB_EN
    bus.sub   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_sum",  bus.sum, 0);
    chk("rst_cout", bus.c_out, 0);
    chk("rst_ofl",  bus.ofl, 0);
    cmp_en = 1'b1;
    rst    = 1'b0;
    @(negedge clk);

    op("basic",  16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    op("wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    op("ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    op("cin",    16'h000F, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0);

    // start while busy is ignored
    drive(16'h0100, 16'h0200, 1'b0, 1'b0);
    wait_done(2, 16'hAAAA, 16'h5555, n);
    chk("ign_lat", n, NIB + 1);
    chk("ign_sum", bus.sum, 16'h0300);
    @(negedge clk);
    chk("ign_busy_after", bus.busy, 0);
    chk("ign_done_after", bus.done, 0);

    // back-to-back acceptance in the done cycle
    drive(16'h1111, 16'h2222, 1'b0, 1'b0);
    wait_done(0, '0, '0, n);
    chk("b2b1_sum", bus.sum, 16'h3333);
    drive(16'h8000, 16'h8000, 1'b0, 1'b0);
    wait_done(0, '0, '0, n2);
    chk("b2b2_gap",   n2, NIB + 1);
    chk("b2b2_sum",   bus.sum, 16'h0000);
    chk("b2b2_c_out", bus.c_out, 1);
    chk("b2b2_ofl",   bus.ofl, 1);

    // reset aborts an operation in flight
    @(negedge clk);
    drive(16'h1234, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_sum",   bus.sum, 0);
    chk("abort_cout",  bus.c_out, 0);
    chk("abort_ofl",   bus.ofl, 0);
    chk("abort_busy",  bus.busy, 0);
    for (int i = 0; i < 8; i++) begin
      chk("abort_no_done", bus.done, 0);
      @(negedge clk);
    end
    op("fresh", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);

`ifdef SEQ_ADD_SUB_EN
    op("sub1", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    op("sub2", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    drive(16'h0001, 16'h0001, 1'b0, 1'b0);
    wait_done(0, '0, '0, n);
`endif

    // model-checked mixed traffic
    for (int i = 0; i < 8; i++) begin
      drive(N'($urandom), N'($urandom), 1'($urandom), 1'b0);
      wait_done(0, '0, '0, n);
      if (i % 2 == 1) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
